// File: rtl/connect_four_pkg.sv
// connect_four_pkg: board geometry, FSM encoding and scan direction table
// shared by the Connect Four controller and its win scanner.
package connect_four_pkg;
   localparam int ROWS  = 6;
   localparam int COLS  = 7;
   localparam int CELLS = ROWS * COLS;
   typedef enum logic [1:0] {IDLE, PLACE, CHECK, DONE} state_t;
   // Directions in scan order: horizontal, vertical, diagonal, anti-diagonal (2-bit signed)
   localparam logic [3:0][1:0] DR = {2'b01, 2'b01, 2'b01, 2'b00};
   localparam logic [3:0][1:0] DC = {2'b11, 2'b01, 2'b00, 2'b01};
   function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
      return 6'(row * COLS + col);
   endfunction
endpackage

// File: rtl/connect_four_win_scan.sv
// connect_four_win_scan: 24-cycle walker that checks the four line directions
// through the last placed piece; done pulses combinationally on the final step.
module connect_four_win_scan
   import connect_four_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic [2:0]       row,
   input  logic [2:0]       col,
   input  logic             player,
   input  logic [CELLS-1:0] empty,
   input  logic [CELLS-1:0] game_data,
   output logic             done,
   output logic             win
);
   logic active, win_r, pos_live, neg_live, neg_side, in_bounds, match, hit;
   logic [1:0] dir, pos_run, neg_run, pos_next, neg_next;
   logic [2:0] step, sum;
   logic [5:0] idx;
   logic signed [4:0] k, dr, dc, r, c;
   always_comb begin
      neg_side = step >= 3'd3;
      k = neg_side ? 5'sd2 - $signed({2'b0, step}) : $signed({2'b0, step}) + 5'sd1;
      dr = {{3{DR[dir][1]}}, DR[dir]};
      dc = {{3{DC[dir][1]}}, DC[dir]};
      r = $signed({2'b0, row}) + k * dr;
      c = $signed({2'b0, col}) + k * dc;
      in_bounds = r >= 5'sd0 && r <= 5'sd5 && c >= 5'sd0 && c <= 5'sd6;
      idx = in_bounds ? cell_idx(r[2:0], c[2:0]) : 6'd0;
      match = in_bounds && empty[idx] && game_data[idx] == player;
      pos_next = pos_run + {1'b0, !neg_side && pos_live && match};
      neg_next = neg_run + {1'b0, neg_side && neg_live && match};
      sum = {1'b0, pos_next} + {1'b0, neg_next};
      hit = active && sum >= 3'd3;
      done = active && dir == 2'd3 && step == 3'd5;
      win = win_r | hit;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset || clear) begin
         active <= 1'b0;
         win_r <= 1'b0;
         dir <= 2'd0;
         step <= 3'd0;
         pos_run <= 2'd0;
         neg_run <= 2'd0;
         pos_live <= 1'b0;
         neg_live <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         win_r <= 1'b0;
         dir <= 2'd0;
         step <= 3'd0;
         pos_run <= 2'd0;
         neg_run <= 2'd0;
         pos_live <= 1'b1;
         neg_live <= 1'b1;
      end else if (active) begin
         win_r <= win;
         if (step == 3'd5) begin
            step <= 3'd0;
            dir <= dir + 2'd1;
            active <= dir != 2'd3;
            pos_run <= 2'd0;
            neg_run <= 2'd0;
            pos_live <= 1'b1;
            neg_live <= 1'b1;
         end else begin
            step <= step + 3'd1;
            pos_run <= pos_next;
            neg_run <= neg_next;
            pos_live <= pos_live & (neg_side | match);
            neg_live <= neg_live & (!neg_side | match);
         end
      end
endmodule

// File: rtl/connect_four_ctrl.sv
// connect_four_ctrl: Connect Four board registers, cursor, move counter and
// game FSM; drives the renderer's game_data/empty vectors.
module connect_four_ctrl
   import connect_four_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             move_left,
   input  logic             move_right,
   input  logic             drop,
   input  logic             new_game,
   output logic [CELLS-1:0] game_data,
   output logic [CELLS-1:0] empty,
   output logic [2:0]       cursor_col,
   output logic             cur_player,
   output logic             busy,
   output logic             game_over,
   output logic             winner_valid,
   output logic             winner
);
   state_t state;
   logic [5:0] moves;
   logic [2:0] tgt_row, tgt_col, free_row;
   logic col_full, scan_done, scan_win;
   // Descending walk so the lowest free row is the one left standing
   always_comb begin
      free_row = 3'd0;
      col_full = 1'b1;
      for (int r = ROWS - 1; r >= 0; r--)
         if (!empty[cell_idx(3'(r), cursor_col)]) begin
            free_row = 3'(r);
            col_full = 1'b0;
         end
   end
   connect_four_win_scan u_scan (
      .clk(clk), .reset(reset), .clear(new_game), .start(state == PLACE),
      .row(tgt_row), .col(tgt_col), .player(cur_player),
      .empty(empty), .game_data(game_data), .done(scan_done), .win(scan_win)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset || new_game) begin
         state <= IDLE;
         game_data <= '0;
         empty <= '0;
         cursor_col <= 3'd3;
         cur_player <= 1'b0;
         busy <= 1'b0;
         game_over <= 1'b0;
         winner_valid <= 1'b0;
         winner <= 1'b0;
         moves <= 6'd0;
         tgt_row <= 3'd0;
         tgt_col <= 3'd0;
      end else
         case (state)
            IDLE:
               if (drop) begin
                  if (!col_full) begin
                     tgt_row <= free_row;
                     tgt_col <= cursor_col;
                     busy <= 1'b1;
                     state <= PLACE;
                  end
               end else if (move_left && !move_right)
                  cursor_col <= cursor_col == 3'd0 ? 3'd0 : cursor_col - 3'd1;
               else if (move_right && !move_left)
                  cursor_col <= cursor_col == 3'd6 ? 3'd6 : cursor_col + 3'd1;
            PLACE: begin
               empty[cell_idx(tgt_row, tgt_col)] <= 1'b1;
               game_data[cell_idx(tgt_row, tgt_col)] <= cur_player;
               moves <= moves + 6'd1;
               state <= CHECK;
            end
            CHECK:
               if (scan_done) begin
                  busy <= 1'b0;
                  if (scan_win) begin
                     state <= DONE;
                     game_over <= 1'b1;
                     winner_valid <= 1'b1;
                     winner <= cur_player;
                  end else if (moves == 6'(CELLS)) begin
                     state <= DONE;
                     game_over <= 1'b1;
                  end else begin
                     cur_player <= ~cur_player;
                     state <= IDLE;
                  end
               end
            default: ;
         endcase
endmodule

// File: tb/tb_connect_four_ctrl.sv
// tb_connect_four_ctrl: scoreboard bench; a board model pushes expected
// outputs per drop, popped and compared once the DUT finishes the move.
module tb_connect_four_ctrl;
   logic clk = 1'b0, reset = 1'b1, move_left = 1'b0, move_right = 1'b0, drop = 1'b0, new_game = 1'b0;
   logic [41:0] game_data, empty;
   logic [2:0] cursor_col;
   logic cur_player, busy, game_over, winner_valid, winner;
   int tests = 0, fails = 0;
   logic [41:0] m_empty, m_data;
   logic m_player, m_over, m_wv, m_win;
   int m_moves, m_cursor;
   string tag_q[$];
   logic [63:0] val_q[$];
   int draw_seq[14] = '{0, 2, 1, 3, 4, 6, 5, 0, 2, 1, 3, 4, 6, 5};

   connect_four_ctrl dut (
      .clk(clk), .reset(reset), .move_left(move_left), .move_right(move_right),
      .drop(drop), .new_game(new_game), .game_data(game_data), .empty(empty),
      .cursor_col(cursor_col), .cur_player(cur_player), .busy(busy),
      .game_over(game_over), .winner_valid(winner_valid), .winner(winner)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      val_q.push_back(v);
   endtask

   task automatic pop_check(input logic [63:0] got);
      if (val_q.size() == 0) check("scoreboard_underflow", 64'd1, 64'd0);
      else check(tag_q.pop_front(), got, val_q.pop_front());
   endtask

   task automatic pulse(input bit l, input bit r);
      move_left = l;
      move_right = r;
      tick();
      move_left = 1'b0;
      move_right = 1'b0;
   endtask

   task automatic model_clear();
      m_empty = '0;
      m_data = '0;
      m_player = 1'b0;
      m_over = 1'b0;
      m_wv = 1'b0;
      m_win = 1'b0;
      m_moves = 0;
      m_cursor = 3;
   endtask

   task automatic start_new_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      model_clear();
   endtask

   task automatic goto(input int col);
      while (m_cursor > col) begin pulse(1, 0); m_cursor--; end
      while (m_cursor < col) begin pulse(0, 1); m_cursor++; end
   endtask

   task automatic drop_piece(input int col, input bit win);
      int row, n;
      bit acc;
      goto(col);
      row = 6;
      for (int r = 5; r >= 0; r--) if (!m_empty[r * 7 + col]) row = r;
      acc = !m_over && row < 6;
      if (acc) begin
         m_empty[row * 7 + col] = 1'b1;
         m_data[row * 7 + col] = m_player;
         m_moves++;
         if (win) begin m_over = 1'b1; m_wv = 1'b1; m_win = m_player; end
         else if (m_moves == 42) m_over = 1'b1;
         else m_player = !m_player;
      end
      push("busy_cycles", acc ? 64'd25 : 64'd0);
      push("empty", 64'(m_empty));
      push("game_data", 64'(m_data));
      push("cur_player", 64'(m_player));
      push("game_over", 64'(m_over));
      push("winner_valid", 64'(m_wv));
      push("winner", 64'(m_win));
      drop = 1'b1;
      tick();
      drop = 1'b0;
      n = 0;
      while (busy && n < 60) begin n++; tick(); end
      pop_check(64'(n));
      pop_check(64'(empty));
      pop_check(64'(game_data));
      pop_check(64'(cur_player));
      pop_check(64'(game_over));
      pop_check(64'(winner_valid));
      pop_check(64'(winner));
   endtask

   initial begin
      model_clear();
      repeat (2) tick();
      reset = 1'b0;
      check("rst_empty", 64'(empty), 64'd0);
      check("rst_game_data", 64'(game_data), 64'd0);
      check("rst_cursor", 64'(cursor_col), 64'd3);
      check("rst_flags", {cur_player, busy, game_over, winner_valid, winner}, 64'd0);

      // Cursor saturation at both ends, simultaneous pulses ignored
      repeat (4) pulse(1, 0);
      check("cursor_left_sat", 64'(cursor_col), 64'd0);
      repeat (5) pulse(0, 1);
      check("cursor_right", 64'(cursor_col), 64'd5);
      pulse(1, 1);
      check("cursor_both", 64'(cursor_col), 64'd5);
      m_cursor = 5;
      drop_piece(5, 0);
      repeat (3) pulse(0, 1);
      check("cursor_right_sat", 64'(cursor_col), 64'd6);
      m_cursor = 6;

      // Column fill: sixth drop fills cell 35, seventh is ignored
      start_new_game();
      check("ng_cursor", 64'(cursor_col), 64'd3);
      repeat (7) drop_piece(0, 0);

      // Bottom-row horizontal win for player 1, then DONE ignores commands
      start_new_game();
      drop_piece(0, 0); drop_piece(6, 0);
      drop_piece(1, 0); drop_piece(6, 0);
      drop_piece(2, 0); drop_piece(6, 0);
      drop_piece(3, 1);
      pulse(1, 0);
      check("done_cursor_frozen", 64'(cursor_col), 64'd3);
      drop_piece(3, 0);

      // Cells 4,5,6 plus 7 must not chain across the row boundary
      start_new_game();
      drop_piece(4, 0); drop_piece(0, 0); drop_piece(5, 0);
      drop_piece(1, 0); drop_piece(6, 0); drop_piece(3, 0);
      drop_piece(0, 0);

      // Diagonal 1-9-17-25 for player 2, closed in the middle at cell 9
      start_new_game();
      drop_piece(2, 0); drop_piece(1, 0); drop_piece(3, 0); drop_piece(4, 0);
      drop_piece(3, 0); drop_piece(3, 0); drop_piece(4, 0); drop_piece(6, 0);
      drop_piece(4, 0); drop_piece(4, 0); drop_piece(0, 0);
      drop_piece(2, 1);

      // Full board with no line of four
      start_new_game();
      for (int rep = 0; rep < 3; rep++)
         for (int i = 0; i < 14; i++) drop_piece(draw_seq[i], 0);

      // new_game ten cycles into CHECK
      start_new_game();
      drop = 1'b1;
      tick();
      drop = 1'b0;
      repeat (11) tick();
      check("midcheck_busy", 64'(busy), 64'd1);
      start_new_game();
      check("ng_empty", 64'(empty), 64'd0);
      check("ng_game_data", 64'(game_data), 64'd0);
      check("ng_cursor_mid", 64'(cursor_col), 64'd3);
      check("ng_busy", 64'(busy), 64'd0);
      drop_piece(3, 0);

      // Asynchronous reset mid-CHECK clears outputs before the next edge
      drop = 1'b1;
      tick();
      drop = 1'b0;
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_empty", 64'(empty), 64'd0);
      check("arst_player", 64'(cur_player), 64'd0);
      #2 reset = 1'b0;
      model_clear();
      tick();
      drop_piece(3, 0);

      check("scoreboard_drained", 64'(val_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
